// File: rtl/maze_loader.sv
// maze_loader: loads a serial 16x16 maze into memory, validates it and starts the solver.
// Optional: define MAZE_LOADER_PARITY_EN to accept and check a trailing even-parity bit.
module maze_loader #(
    parameter int CELLS = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ldStart,
    input  logic          bitIn,
    input  logic          bitVld,
    input  logic          abort,
    output logic [AW-1:0] loc,
    output logic          dOut,
    output logic          wr,
    output logic          memSel,
    output logic          start,
    output logic          busy,
    output logic          loadDone,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAR,
        CHK,
        GO
    } state_t;

`ifdef MAZE_LOADER_PARITY_EN
    localparam state_t AFTER_LOAD = PAR;
`else
    localparam state_t AFTER_LOAD = CHK;
`endif

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          first_q;
    logic          last_q;
    logic          done_q;
    logic          err_q;
    logic          start_q;
    logic          accept;
    logic          last_cell;
    logic          fault;

`ifdef MAZE_LOADER_PARITY_EN
    logic par_q;
    logic par_d;
    assign par_d = par_q ^ bitIn;
    assign fault = first_q | last_q | par_q;
`else
    assign fault = first_q | last_q;
`endif

    // Abort beats a coincident valid bit: nothing reaches memory.
    assign accept    = (state_q == LOAD) && bitVld && !abort;
    assign last_cell = (cnt_q == AW'(CELLS - 1));

    assign wr       = accept;
    assign dOut     = accept & bitIn;
    assign loc      = cnt_q;
    assign memSel   = (state_q == LOAD) || (state_q == PAR);
    assign busy     = (state_q != IDLE);
    assign start    = start_q;
    assign loadDone = done_q;
    assign err      = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
`ifdef MAZE_LOADER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ldStart) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                        first_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
`ifdef MAZE_LOADER_PARITY_EN
                        par_q   <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (bitVld) begin
                        cnt_q <= cnt_q + 1'b1;
`ifdef MAZE_LOADER_PARITY_EN
                        par_q <= par_d;
`endif
                        if (cnt_q == '0) begin
                            first_q <= bitIn;
                        end
                        if (last_cell) begin
                            last_q  <= bitIn;
                            state_q <= AFTER_LOAD;
                        end
                    end
                end
`ifdef MAZE_LOADER_PARITY_EN
                PAR: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (bitVld) begin
                        par_q   <= par_d;
                        state_q <= CHK;
                    end
                end
`endif
                CHK: begin
                    if (fault) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        done_q  <= 1'b1;
                        start_q <= 1'b1;
                        state_q <= GO;
                    end
                end
                GO: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_loader.sv
// tb_maze_loader: randomized load streams checked every cycle against a
// transaction-level model of the maze loader.
module tb_maze_loader;

`ifdef MAZE_LOADER_PARITY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ldStart = 1'b0;
    logic       bitIn = 1'b0;
    logic       bitVld = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] loc;
    logic       dOut;
    logic       wr;
    logic       memSel;
    logic       start;
    logic       busy;
    logic       loadDone;
    logic       err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int starts = 0;
    int wrs = 0;
    int start_cyc = 0;
    int ld_cyc = 0;

    bit pat[256];
    bit shmem[256];

    // Model: a load is a run of accepted bits; after the last one comes
    // one check cycle and, if the maze is legal, one start cycle.
    bit m_act;
    int m_n;
    int m_post;
    bit m_done;
    bit m_err;
    bit m_acc;
    bit m_maze[256];
    bit exp_wr;

    always #5 clk = ~clk;

    maze_loader dut (
        .clk(clk),
        .rst(rst),
        .ldStart(ldStart),
        .bitIn(bitIn),
        .bitVld(bitVld),
        .abort(abort),
        .loc(loc),
        .dOut(dOut),
        .wr(wr),
        .memSel(memSel),
        .start(start),
        .busy(busy),
        .loadDone(loadDone),
        .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act  = 1'b0;
            m_n    = 0;
            m_post = 0;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_acc  = 1'b0;
        end else begin
            cyc++;
            if (m_act) begin
                if (abort) begin
                    m_act = 1'b0;
                end else if (bitVld) begin
                    m_acc = m_acc ^ bitIn;
                    if (m_n < 256) m_maze[m_n] = bitIn;
                    m_n++;
                    if (m_n == 256 + PEN) begin
                        m_act  = 1'b0;
                        m_post = 1;
                    end
                end
            end else if (m_post == 1) begin
                if (m_maze[0] || m_maze[255] || (PEN == 1 && m_acc)) begin
                    m_err  = 1'b1;
                    m_post = 0;
                end else begin
                    m_done = 1'b1;
                    m_post = 2;
                end
            end else if (m_post == 2) begin
                m_post = 0;
            end else if (ldStart) begin
                m_act  = 1'b1;
                m_n    = 0;
                m_done = 1'b0;
                m_err  = 1'b0;
                m_acc  = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst && wr === 1'b1) begin
            shmem[loc] <= dOut;
            wrs <= wrs + 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_wr = m_act && m_n < 256 && bitVld && !abort;
            chk("busy", busy, 32'(m_act || m_post != 0));
            chk("memSel", memSel, 32'(m_act));
            chk("wr", wr, 32'(exp_wr));
            if (exp_wr) begin
                chk("loc", loc, 32'(m_n[7:0]));
                chk("dOut", dOut, 32'(bitIn));
            end
            chk("start", start, 32'(m_post == 2));
            chk("loadDone", loadDone, 32'(m_done));
            chk("err", err, 32'(m_err));
            if (start === 1'b1) begin
                starts++;
                start_cyc = cyc;
            end
        end
    end

    task automatic step(input bit ld, input bit bv, input bit bi, input bit ab);
        @(posedge clk);
        #1;
        ldStart = ld;
        bitVld  = bv;
        bitIn   = bi;
        abort   = ab;
    endtask

    task automatic run_load(input int gap_pct, input bit pbit, input bit ld_bit);
        int i;
        i = 0;
        step(1'b1, ld_bit, 1'b1, 1'b0);
        ld_cyc = cyc;
        while (i < 256 + PEN) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                step(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)), 1'b0);
            end else begin
                step(gap_pct > 0 && $urandom_range(1) == 1, 1'b1,
                     (i < 256) ? pat[i] : pbit, 1'b0);
                i++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, k == 0, 1'b1, k == 1);
        end
    endtask

    function automatic int mem_mism();
        int m;
        m = 0;
        for (int i = 0; i < 256; i++) begin
            if (shmem[i] != pat[i]) m++;
        end
        return m;
    endfunction

    function automatic bit pattern_par();
        bit p;
        p = 1'b0;
        for (int i = 0; i < 256; i++) p ^= pat[i];
        return p;
    endfunction

    int s0;
    int w0;
    bit pb;
    bit ok;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_wr", wr, 0);
        chk("rst_loc", loc, 0);
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("idle_start", start, 0);
        chk("idle_memSel", memSel, 0);
        chk("idle_loadDone", loadDone, 0);
        chk("idle_err", err, 0);

        // all-zero maze at full rate
        for (int i = 0; i < 256; i++) pat[i] = 1'b0;
        s0 = starts;
        w0 = wrs;
        run_load(0, 1'b0, 1'b0);
        chk("zero_starts", starts - s0, 1);
        chk("zero_latency", start_cyc - ld_cyc, 258 + PEN);
        chk("zero_writes", wrs - w0, 256);
        chk("zero_mem", mem_mism(), 0);
        chk("zero_done", loadDone, 1);
        chk("zero_err", err, 0);

        // exit cell walled
        pat[255] = 1'b1;
        s0 = starts;
        w0 = wrs;
        run_load(0, 1'b1, 1'b0);
        chk("wall_starts", starts - s0, 0);
        chk("wall_writes", wrs - w0, 256);
        chk("wall_err", err, 1);
        chk("wall_done", loadDone, 0);
        chk("wall_busy", busy, 0);

        // abort after 100 cells
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (100) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("abort_wr", wr, 0);
        chk("abort_loc", loc, 100);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_busy", busy, 0);
        chk("abort_done", loadDone, 0);
        chk("abort_err", err, 0);

        // checkerboard with 50% gaps, ldStart paired with a dropped bit
        for (int i = 0; i < 256; i++) pat[i] = 1'(((i >> 4) + (i & 15)) & 1);
        s0 = starts;
        w0 = wrs;
        run_load(50, 1'b0, 1'b1);
        chk("chk_starts", starts - s0, 1);
        chk("chk_writes", wrs - w0, 256);
        chk("chk_mem", mem_mism(), 0);

        // seven walls, even parity needs parity bit 1
        for (int i = 0; i < 256; i++) pat[i] = 1'b0;
        pat[1] = 1'b1; pat[17] = 1'b1; pat[34] = 1'b1; pat[51] = 1'b1;
        pat[68] = 1'b1; pat[85] = 1'b1; pat[102] = 1'b1;
        s0 = starts;
        run_load(0, 1'b1, 1'b0);
        chk("p1_starts", starts - s0, 1);
        chk("p1_err", err, 0);
        s0 = starts;
        run_load(20, 1'b0, 1'b0);
        chk("p0_starts", starts - s0, 1 - PEN);
        chk("p0_err", err, PEN);

        // random mazes
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 256; i++) pat[i] = ($urandom_range(99) < 30);
            pat[0] = ($urandom_range(3) == 0);
            pat[255] = ($urandom_range(3) == 0);
            pb = pattern_par() ^ ($urandom_range(3) == 0);
            ok = !pat[0] && !pat[255] && (PEN == 0 || (pattern_par() ^ pb) == 1'b0);
            s0 = starts;
            run_load(30, pb, 1'($urandom_range(1)));
            chk("rnd_starts", starts - s0, 32'(ok));
            chk("rnd_err", err, 32'(!ok));
            chk("rnd_mem", mem_mism(), 0);
        end

        // reset during load at cnt 50
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (50) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_wr", wr, 0);
        chk("rstmid_loc", loc, 0);
        chk("rstmid_dOut", dOut, 0);
        chk("rstmid_memSel", memSel, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_start", start, 0);
        chk("rstmid_flags", {loadDone, err}, 0);
        @(posedge clk);
        #1;
        bitVld = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 256; i++) pat[i] = (i % 5 == 2);
        s0 = starts;
        run_load(10, pattern_par(), 1'b0);
        chk("after_rst_starts", starts - s0, 1);
        chk("after_rst_mem", mem_mism(), 0);

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
